// File: rtl/des_key_expand.sv
// DES key expansion: PC-1 load, 16 iterated schedule rounds into a round-key table, registered read port.
// Build option: define DES_KEY_EXPAND_ZEROISE_EN to clear the table when a new key is accepted.

module des_ks_stage (
  input  logic [55:0] x,
  input  logic [3:0]  i,
  output logic [55:0] r,
  output logic [47:0] k
);
  localparam int unsigned PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  logic one;

  always_comb begin
    one = (i == 4'd0) || (i == 4'd1) || (i == 4'd8) || (i == 4'd15);
    if (one) r = {x[54:28], x[55], x[26:0], x[27]};
    else     r = {x[53:28], x[55:54], x[25:0], x[27:26]};
    k = '0;
    for (int unsigned n = 0; n < 48; n++)
      k[6'(47 - n)] = r[6'(56 - PC2_T[n])];
  end
endmodule

module des_key_expand (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [63:0] key,
  output logic        ack,
  output logic        busy,
  output logic        valid,
  input  logic [3:0]  rd_idx,
  input  logic        rd_dec,
  output logic [47:0] rd_key
);
  localparam int unsigned PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_n;
  logic [55:0] cd, cd_init, r;
  logic [3:0]  rnd, ridx;
  logic [47:0] k;
  logic [47:0] tbl [16];
  logic        accept, step, drop;

  always_comb begin
    cd_init = '0;
    for (int unsigned n = 0; n < 56; n++)
      cd_init[6'(55 - n)] = key[6'(64 - PC1_T[n])];
  end

  des_ks_stage u_stage (.x(cd), .i(rnd), .r(r), .k(k));

  // 15 - rd_idx is the bitwise complement for a 4-bit index
  assign ridx = rd_dec ? ~rd_idx : rd_idx;

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    step    = 1'b0;
    drop    = 1'b0;
    case (state)
      IDLE: if (req) begin
        accept  = 1'b1;
        state_n = RUN;
      end
      RUN: begin
        step = 1'b1;
        if (rnd == 4'd15) state_n = DONE;
      end
      DONE: if (!req) begin
        drop    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cd     <= '0;
      rnd    <= '0;
      ack    <= 1'b0;
      busy   <= 1'b0;
      valid  <= 1'b0;
      rd_key <= '0;
      for (int unsigned n = 0; n < 16; n++) tbl[4'(n)] <= '0;
    end else begin
      if (accept) begin
        cd    <= cd_init;
        rnd   <= '0;
        valid <= 1'b0;
        busy  <= 1'b1;
`ifdef DES_KEY_EXPAND_ZEROISE_EN
        for (int unsigned n = 0; n < 16; n++) tbl[4'(n)] <= '0;
`endif
      end
      if (step) begin
        cd       <= r;
        tbl[rnd] <= k;
        rnd      <= rnd + 4'd1;
        if (rnd == 4'd15) begin
          busy  <= 1'b0;
          valid <= 1'b1;
          ack   <= 1'b1;
        end
      end
      if (drop) ack <= 1'b0;
      rd_key <= tbl[ridx];
    end
  end
endmodule
